// File: rtl/mem_arbiter.sv
// mem_arbiter
//
// Shares the single-ported data memory between the instruction-fetch port
// and the data (load/store) port. One transaction is in flight at a time:
// the winner's request is captured onto the memory bus, held for
// MEM_LATENCY cycles, and a one-cycle rvalid pulse returns the read data
// to the owner. The data port has fixed priority, but a starvation counter
// forces fetch to win after STARVE_LIMIT consecutive data wins over a
// pending fetch.
//
// Parameters
//   MEM_LATENCY   cycles the memory bus is held per access (1..7)
//   STARVE_LIMIT  data wins over a pending fetch before fetch is forced (1..15)
//
// Ports
//   clk, reset              rising-edge clock, asynchronous active-high reset
//   if_req/if_addr          fetch request and byte address
//   if_gnt                  fetch accepted this cycle (combinational)
//   if_rvalid/if_rdata      fetch response pulse and fetched word
//   d_req/d_we/d_size/d_ext data request, store flag, size, load sign-extend
//   d_addr/d_wdata          data byte address and store data
//   d_gnt                   data accepted this cycle (combinational)
//   d_rvalid/d_rdata        data response pulse and load data
//   mem_*                   registered memory bus; mem_rdata is combinational
//                           from mem_addr
module mem_arbiter #(
    parameter int unsigned MEM_LATENCY  = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [0:31] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [0:31] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [0:1]  d_size,
    input  logic        d_ext,
    input  logic [0:31] d_addr,
    input  logic [0:31] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [0:31] d_rdata,
    output logic [0:31] mem_addr,
    output logic [0:31] mem_wdata,
    output logic        mem_we,
    output logic [0:1]  mem_size,
    output logic        mem_ext,
    input  logic [0:31] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        RESP = 2'b10
    } state_t;

    localparam logic [2:0] LAT_MAX    = 3'(MEM_LATENCY);
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    state_t      state_q,     state_d;
    logic [2:0]  cnt_q,       cnt_d;
    logic [3:0]  starve_q,    starve_d;
    logic        owner_d_q,   owner_d_d;     // 1 = data port owns the access
    logic [0:31] mem_addr_q,  mem_addr_d;
    logic [0:31] mem_wdata_q, mem_wdata_d;
    logic [0:1]  mem_size_q,  mem_size_d;
    logic        mem_ext_q,   mem_ext_d;
    logic        mem_we_q,    mem_we_d;
    logic        if_rvalid_q, if_rvalid_d;
    logic        d_rvalid_q,  d_rvalid_d;
    logic [0:31] if_rdata_q,  if_rdata_d;
    logic [0:31] d_rdata_q,   d_rdata_d;

    logic        can_grant;
    logic        if_win;
    logic        d_win;

    // Grants are only possible when nothing is in flight or the response is
    // being presented; held off while reset is asserted so gnt reads 0.
    assign can_grant = ((state_q == IDLE) || (state_q == RESP)) && !reset;

    // Arbitration: data wins unless fetch has been starved up to the limit.
    always_comb begin
        if_win = 1'b0;
        d_win  = 1'b0;
        if (can_grant) begin
            if (if_req && d_req) begin
                if (starve_q == STARVE_MAX) begin
                    if_win = 1'b1;
                end else begin
                    d_win = 1'b1;
                end
            end else begin
                if_win = if_req;
                d_win  = d_req;
            end
        end else begin
            if_win = 1'b0;
            d_win  = 1'b0;
        end
    end

    // Starvation counter: counts data wins over a waiting fetch, saturating.
    always_comb begin
        starve_d = starve_q;
        if (if_win) begin
            starve_d = 4'd0;
        end else if (d_win && if_req && (starve_q < STARVE_MAX)) begin
            starve_d = starve_q + 4'd1;
        end else begin
            starve_d = starve_q;
        end
    end

    // Transaction sequencing: capture on grant, count latency, respond.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        owner_d_d   = owner_d_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_size_d  = mem_size_q;
        mem_ext_d   = mem_ext_q;
        mem_we_d    = 1'b0;            // write strobe lasts one BUSY cycle
        if_rvalid_d = 1'b0;
        d_rvalid_d  = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;

        case (state_q)
            IDLE, RESP: begin
                if (if_win) begin
                    state_d    = BUSY;
                    cnt_d      = 3'd1;
                    owner_d_d  = 1'b0;
                    mem_addr_d = if_addr;
                    mem_size_d = 2'b11;
                    mem_ext_d  = 1'b0;
                    mem_we_d   = 1'b0;
                end else if (d_win) begin
                    state_d     = BUSY;
                    cnt_d       = 3'd1;
                    owner_d_d   = 1'b1;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    mem_size_d  = d_size;
                    mem_ext_d   = d_ext;
                    mem_we_d    = d_we;
                end else begin
                    state_d = IDLE;
                    cnt_d   = 3'd0;
                end
            end
            BUSY: begin
                if (cnt_q == LAT_MAX) begin
                    state_d = RESP;
                    cnt_d   = 3'd0;
                    if (owner_d_q) begin
                        d_rdata_d  = mem_rdata;
                        d_rvalid_d = 1'b1;
                    end else begin
                        if_rdata_d  = mem_rdata;
                        if_rvalid_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 3'd0;
            end
        endcase
    end

    // State and output registers; reset abandons any in-flight access.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 3'd0;
            starve_q    <= 4'd0;
            owner_d_q   <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            mem_size_q  <= 2'b00;
            mem_ext_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            if_rdata_q  <= 32'h0;
            d_rdata_q   <= 32'h0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            starve_q    <= starve_d;
            owner_d_q   <= owner_d_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_size_q  <= mem_size_d;
            mem_ext_q   <= mem_ext_d;
            mem_we_q    <= mem_we_d;
            if_rvalid_q <= if_rvalid_d;
            d_rvalid_q  <= d_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign if_gnt    = if_win;
    assign d_gnt     = d_win;
    assign if_rvalid = if_rvalid_q;
    assign d_rvalid  = d_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;
    assign mem_size  = mem_size_q;
    assign mem_ext   = mem_ext_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter. DUT "a" uses MEM_LATENCY=2, STARVE_LIMIT=2;
// DUT "b" uses MEM_LATENCY=1 and only sees fetch traffic. Each DUT has a
// simple word-addressed memory attached to its bus.
module tb_mem_arbiter;

    localparam int LA = 2;
    localparam int SA = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        a_if_req, a_if_gnt, a_if_rvalid;
    logic [0:31] a_if_addr, a_if_rdata;
    logic        a_d_req, a_d_we, a_d_ext, a_d_gnt, a_d_rvalid;
    logic [0:1]  a_d_size, a_mem_size;
    logic [0:31] a_d_addr, a_d_wdata, a_d_rdata;
    logic [0:31] a_mem_addr, a_mem_wdata, a_mem_rdata;
    logic        a_mem_we, a_mem_ext;

    logic        b_if_req, b_if_gnt, b_if_rvalid;
    logic [0:31] b_if_addr, b_if_rdata;
    logic        b_d_req, b_d_we, b_d_ext, b_d_gnt, b_d_rvalid;
    logic [0:1]  b_d_size, b_mem_size;
    logic [0:31] b_d_addr, b_d_wdata, b_d_rdata;
    logic [0:31] b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic        b_mem_we, b_mem_ext;

    mem_arbiter #(.MEM_LATENCY(LA), .STARVE_LIMIT(SA)) u_a (
        .clk(clk), .reset(reset),
        .if_req(a_if_req), .if_addr(a_if_addr), .if_gnt(a_if_gnt),
        .if_rvalid(a_if_rvalid), .if_rdata(a_if_rdata),
        .d_req(a_d_req), .d_we(a_d_we), .d_size(a_d_size), .d_ext(a_d_ext),
        .d_addr(a_d_addr), .d_wdata(a_d_wdata), .d_gnt(a_d_gnt),
        .d_rvalid(a_d_rvalid), .d_rdata(a_d_rdata),
        .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_we(a_mem_we),
        .mem_size(a_mem_size), .mem_ext(a_mem_ext), .mem_rdata(a_mem_rdata)
    );

    mem_arbiter #(.MEM_LATENCY(1), .STARVE_LIMIT(4)) u_b (
        .clk(clk), .reset(reset),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt),
        .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
        .d_req(b_d_req), .d_we(b_d_we), .d_size(b_d_size), .d_ext(b_d_ext),
        .d_addr(b_d_addr), .d_wdata(b_d_wdata), .d_gnt(b_d_gnt),
        .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
        .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_we(b_mem_we),
        .mem_size(b_mem_size), .mem_ext(b_mem_ext), .mem_rdata(b_mem_rdata)
    );

    // Memories: 256 words, byte address bits [9:2] select the word.
    logic [31:0] mem_a [256];
    logic [31:0] mem_b [256];
    logic        pl_en;
    int          pl_idx;
    logic [31:0] pl_dat;

    function automatic int widx(input logic [0:31] ad);
        logic [31:0] v;
        v = ad;
        return int'(v[9:2]);
    endfunction

    assign a_mem_rdata = mem_a[widx(a_mem_addr)];
    assign b_mem_rdata = mem_b[widx(b_mem_addr)];

    always @(posedge clk) begin
        if (pl_en) begin
            mem_a[pl_idx] <= pl_dat;
            mem_b[pl_idx] <= pl_dat;
        end else if (a_mem_we) begin
            mem_a[widx(a_mem_addr)] <= a_mem_wdata;
        end
    end

    int nvec = 0;
    int nmis = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic preload(input int idx, input logic [31:0] dat);
        pl_en  = 1'b1;
        pl_idx = idx;
        pl_dat = dat;
        @(posedge clk);
        #1;
        pl_en = 1'b0;
    endtask

    // One complete transaction on DUT a, starting from an idle arbiter.
    task automatic run_txn(input bit is_d, input bit we, input logic [31:0] addr,
                           input logic [31:0] wd, input bit chk_rd,
                           input logic [31:0] exp_rd, input string tag);
        if (is_d) begin
            a_d_req = 1'b1; a_d_we = we; a_d_addr = addr; a_d_wdata = wd;
            a_d_size = 2'b11; a_d_ext = 1'b0;
        end else begin
            a_if_req = 1'b1; a_if_addr = addr;
        end
        @(negedge clk);
        chk({tag, " gnt"}, is_d ? a_d_gnt : a_if_gnt, 32'd1);
        @(posedge clk); #1;
        a_if_req = 1'b0; a_d_req = 1'b0;
        for (int k = 1; k <= LA; k++) begin
            @(negedge clk);
            chk({tag, " mem_addr"}, a_mem_addr, addr);
            chk({tag, " mem_we"}, a_mem_we, (we && k == 1) ? 32'd1 : 32'd0);
            chk({tag, " mem_size"}, a_mem_size, 32'd3);
            chk({tag, " early rvalid"}, is_d ? a_d_rvalid : a_if_rvalid, 32'd0);
            if (we) chk({tag, " mem_wdata"}, a_mem_wdata, wd);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk({tag, " rvalid"}, is_d ? a_d_rvalid : a_if_rvalid, 32'd1);
        chk({tag, " mem_we idle"}, a_mem_we, 32'd0);
        if (chk_rd) chk({tag, " rdata"}, is_d ? a_d_rdata : a_if_rdata, exp_rd);
        @(posedge clk); #1;
        @(negedge clk);
        chk({tag, " rvalid drop"}, is_d ? a_d_rvalid : a_if_rvalid, 32'd0);
        @(posedge clk); #1;
    endtask

    typedef struct packed {
        logic ifr, dr;        // inputs: if_req, d_req
        logic e_ifg, e_dg;    // expected if_gnt, d_gnt
        logic e_ifv, e_dv;    // expected if_rvalid, d_rvalid
    } vec_t;
    vec_t vt [26];

    // Reference model state for the random phase.
    logic [31:0] model_mem [256];
    int          resp_at, gnt_at, starve_m;
    bit          own_d, we_m, ext_m, d_known, free, eg_if, eg_d, ev_if, ev_d;
    logic [31:0] addr_m, wdata_m, exp_rd, last_if_rd, last_d_rd;
    logic [1:0]  size_m;

    initial begin
        // Contention (STARVE_LIMIT irrelevant): d wins, fetch back-to-back in RESP.
        vt[0]  = 6'b11_01_00;  vt[1]  = 6'b10_00_00;  vt[2]  = 6'b10_00_00;
        vt[3]  = 6'b10_10_01;  vt[4]  = 6'b00_00_00;  vt[5]  = 6'b00_00_00;
        vt[6]  = 6'b00_00_10;
        // Starvation with both requests held: d, d, if, d, d, if, d.
        vt[7]  = 6'b11_01_00;  vt[8]  = 6'b11_00_00;  vt[9]  = 6'b11_00_00;
        vt[10] = 6'b11_01_01;  vt[11] = 6'b11_00_00;  vt[12] = 6'b11_00_00;
        vt[13] = 6'b11_10_01;  vt[14] = 6'b11_00_00;  vt[15] = 6'b11_00_00;
        vt[16] = 6'b11_01_10;  vt[17] = 6'b11_00_00;  vt[18] = 6'b11_00_00;
        vt[19] = 6'b11_01_01;  vt[20] = 6'b11_00_00;  vt[21] = 6'b11_00_00;
        vt[22] = 6'b11_10_01;  vt[23] = 6'b11_00_00;  vt[24] = 6'b11_00_00;
        vt[25] = 6'b11_01_10;

        reset = 1'b1; pl_en = 1'b0; pl_idx = 0; pl_dat = 32'h0;
        a_if_req = 1'b0; a_if_addr = 32'h0; a_d_req = 1'b0; a_d_we = 1'b0;
        a_d_size = 2'b00; a_d_ext = 1'b0; a_d_addr = 32'h0; a_d_wdata = 32'h0;
        b_if_req = 1'b0; b_if_addr = 32'h0; b_d_req = 1'b0; b_d_we = 1'b0;
        b_d_size = 2'b00; b_d_ext = 1'b0; b_d_addr = 32'h0; b_d_wdata = 32'h0;

        preload(0, 32'hDEADBEEF);
        preload(2, 32'hCAFEF00D);
        @(negedge clk);
        chk("reset if_gnt", a_if_gnt, 32'd0);
        chk("reset d_gnt", a_d_gnt, 32'd0);
        chk("reset if_rvalid", a_if_rvalid, 32'd0);
        chk("reset d_rvalid", a_d_rvalid, 32'd0);
        chk("reset mem_addr", a_mem_addr, 32'd0);
        chk("reset mem_we", a_mem_we, 32'd0);
        chk("reset mem_size", a_mem_size, 32'd0);
        chk("reset if_rdata", a_if_rdata, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Single fetch, store then load.
        run_txn(1'b0, 1'b0, 32'h2000, 32'h0, 1'b1, 32'hDEADBEEF, "fetch");
        run_txn(1'b1, 1'b1, 32'h2004, 32'h12345678, 1'b0, 32'h0, "store");
        run_txn(1'b1, 1'b0, 32'h2004, 32'h0, 1'b1, 32'h12345678, "load");

        // Reset in cycle 1 of a load: everything clears, no response appears.
        a_d_req = 1'b1; a_d_we = 1'b0; a_d_addr = 32'h2000;
        @(negedge clk);
        chk("rst-mid gnt", a_d_gnt, 32'd1);
        @(posedge clk); #1;
        a_d_req = 1'b0;
        reset = 1'b1;
        #1;
        chk("rst-mid d_gnt", a_d_gnt, 32'd0);
        chk("rst-mid if_gnt", a_if_gnt, 32'd0);
        chk("rst-mid d_rdata", a_d_rdata, 32'd0);
        chk("rst-mid if_rdata", a_if_rdata, 32'd0);
        chk("rst-mid mem_addr", a_mem_addr, 32'd0);
        chk("rst-mid mem_wdata", a_mem_wdata, 32'd0);
        chk("rst-mid mem_size", a_mem_size, 32'd0);
        chk("rst-mid mem_ext", a_mem_ext, 32'd0);
        chk("rst-mid mem_we", a_mem_we, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("rst-mid no d_rvalid", a_d_rvalid, 32'd0);
            @(posedge clk); #1;
        end
        run_txn(1'b1, 1'b0, 32'h2004, 32'h0, 1'b1, 32'h12345678, "post-rst load");

        // MEM_LATENCY=1: grant every 2nd cycle, rvalid 2 cycles after grant.
        b_if_addr = 32'h2008;
        for (int i = 0; i < 10; i++) begin
            b_if_req = (i < 8);
            @(negedge clk);
            chk("lat1 if_gnt", b_if_gnt, (i < 8 && i % 2 == 0) ? 32'd1 : 32'd0);
            chk("lat1 if_rvalid", b_if_rvalid, (i >= 2 && i <= 8 && i % 2 == 0) ? 32'd1 : 32'd0);
            if (i >= 2 && i <= 8 && i % 2 == 0) chk("lat1 if_rdata", b_if_rdata, 32'hCAFEF00D);
            @(posedge clk); #1;
        end
        b_if_req = 1'b0;

        // Table-driven contention / starvation cycles.
        a_if_addr = 32'h2010; a_d_addr = 32'h2014; a_d_we = 1'b0;
        for (int i = 0; i < 26; i++) begin
            a_if_req = vt[i].ifr;
            a_d_req  = vt[i].dr;
            @(negedge clk);
            chk($sformatf("tbl[%0d] if_gnt", i), a_if_gnt, 32'(vt[i].e_ifg));
            chk($sformatf("tbl[%0d] d_gnt", i), a_d_gnt, 32'(vt[i].e_dg));
            chk($sformatf("tbl[%0d] if_rvalid", i), a_if_rvalid, 32'(vt[i].e_ifv));
            chk($sformatf("tbl[%0d] d_rvalid", i), a_d_rvalid, 32'(vt[i].e_dv));
            @(posedge clk); #1;
        end
        a_if_req = 1'b0; a_d_req = 1'b0;

        // Random traffic against a transaction-level model.
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_mem = mem_a;
        resp_at = -1; gnt_at = -10; starve_m = 0; own_d = 1'b0; we_m = 1'b0;
        ext_m = 1'b0; d_known = 1'b1; addr_m = 32'h0; wdata_m = 32'h0;
        size_m = 2'b00; exp_rd = 32'h0; last_if_rd = 32'h0; last_d_rd = 32'h0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            free = (resp_at <= cyc);
            eg_if = 1'b0; eg_d = 1'b0;
            if (free) begin
                if (a_if_req && a_d_req) begin
                    if (starve_m == SA) eg_if = 1'b1; else eg_d = 1'b1;
                end else begin
                    eg_if = a_if_req; eg_d = a_d_req;
                end
            end
            ev_if = (resp_at == cyc) && !own_d;
            ev_d  = (resp_at == cyc) && own_d;
            if (ev_if) last_if_rd = exp_rd;
            if (ev_d) begin
                if (we_m) d_known = 1'b0;
                else begin d_known = 1'b1; last_d_rd = exp_rd; end
            end
            chk("rnd if_gnt", a_if_gnt, 32'(eg_if));
            chk("rnd d_gnt", a_d_gnt, 32'(eg_d));
            chk("rnd if_rvalid", a_if_rvalid, 32'(ev_if));
            chk("rnd d_rvalid", a_d_rvalid, 32'(ev_d));
            chk("rnd if_rdata", a_if_rdata, last_if_rd);
            if (d_known) chk("rnd d_rdata", a_d_rdata, last_d_rd);
            chk("rnd mem_addr", a_mem_addr, addr_m);
            chk("rnd mem_wdata", a_mem_wdata, wdata_m);
            chk("rnd mem_size", a_mem_size, 32'(size_m));
            chk("rnd mem_ext", a_mem_ext, 32'(ext_m));
            chk("rnd mem_we", a_mem_we, (cyc == gnt_at + 1 && we_m) ? 32'd1 : 32'd0);
            if (eg_d && a_if_req && starve_m < SA) starve_m++;
            if (eg_if) starve_m = 0;
            if (eg_if || eg_d) begin
                gnt_at = cyc; resp_at = cyc + LA + 1; own_d = eg_d;
                if (eg_if) begin
                    addr_m = a_if_addr; size_m = 2'b11; ext_m = 1'b0; we_m = 1'b0;
                    exp_rd = model_mem[widx(a_if_addr)];
                end else begin
                    addr_m = a_d_addr; wdata_m = a_d_wdata; size_m = a_d_size;
                    ext_m = a_d_ext; we_m = a_d_we;
                    if (a_d_we) model_mem[widx(a_d_addr)] = a_d_wdata;
                    else exp_rd = model_mem[widx(a_d_addr)];
                end
            end
            @(posedge clk); #1;
            if (!a_if_req || eg_if) begin
                a_if_req  = ($urandom_range(0, 9) < 4);
                a_if_addr = 32'h2000 + 32'(4 * $urandom_range(0, 15));
            end else if ($urandom_range(0, 19) == 0) begin
                a_if_req = 1'b0;
            end
            if (!a_d_req || eg_d) begin
                a_d_req   = ($urandom_range(0, 9) < 4);
                a_d_we    = 1'($urandom_range(0, 1));
                a_d_size  = 2'($urandom_range(0, 3));
                a_d_ext   = 1'($urandom_range(0, 1));
                a_d_addr  = 32'h2000 + 32'(4 * $urandom_range(0, 15));
                a_d_wdata = $urandom;
            end else if ($urandom_range(0, 19) == 0) begin
                a_d_req = 1'b0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single-ported data memory (`dmem`) between the pipelined processor's instruction-fetch port and its data (load/store) port. It accepts one transaction at a time, drives the memory bus for a fixed access latency and returns a one-cycle response pulse to the winning requester. The data port has fixed priority over fetch, and a starvation counter guarantees that fetch makes progress. It sits between the processor's `ifetch`/memory stages and `dmem`; the processor uses `gnt`/`rvalid` to generate its stalls.

## Interface
- `MEM_LATENCY`, default 2: cycles the memory bus is held per access; legal range 1..7.
- `STARVE_LIMIT`, default 4: consecutive data-port wins over a pending fetch before fetch is forced to win; legal range 1..15.

- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `if_req`  in  1  fetch read request; held until `if_gnt`.
- `if_addr`  in  [0:31]  fetch byte address.
- `if_gnt`  out  1  fetch request accepted this cycle.
- `if_rvalid`  out  1  one-cycle pulse; `if_rdata` valid.
- `if_rdata`  out  [0:31]  fetched word.
- `d_req`  in  1  data request; held until `d_gnt`.
- `d_we`  in  1  1 = store, 0 = load.
- `d_size`  in  [0:1]  access size, passed to `mem_size`.
- `d_ext`  in  1  sign-extend loads, passed to `mem_ext`.
- `d_addr`  in  [0:31]  data byte address.
- `d_wdata`  in  [0:31]  store data.
- `d_gnt`  out  1  data request accepted this cycle.
- `d_rvalid`  out  1  one-cycle pulse; load data valid, or store completed.
- `d_rdata`  out  [0:31]  load data; value is undefined after a store.
- `mem_addr`  out  [0:31]  memory address.
- `mem_wdata`  out  [0:31]  memory write data.
- `mem_we`  out  1  memory write enable.
- `mem_size`  out  [0:1]  memory access size; fetch always drives word size (2'b11).
- `mem_ext`  out  1  memory sign-extend; fetch drives 0.
- `mem_rdata`  in  [0:31]  memory read data; combinational from `mem_addr`.

## Operation
- **States**
  - `IDLE`: no transaction in flight; requests can be granted.
  - `BUSY`: counter `cnt` runs 1..`MEM_LATENCY`.
  - `RESP`: one cycle; the response is presented.
- **Grant**
  - Grant is combinational. It is issued only in `IDLE` or `RESP`, and only when a request is present.
  - With only one request, that requester wins.
  - With both requests, `d` wins unless `starve == STARVE_LIMIT`, in which case `if` wins.
  - At most one `gnt` per cycle.
- **Capture at grant edge**
  - The winner's address, data, size, ext and we are registered onto the `mem_*` outputs.
  - The owner (`if`/`d`) is recorded and the state moves to `BUSY` with `cnt = 1`.
- **BUSY**
  - `mem_*` outputs are held constant.
  - `mem_we` is high only in the first `BUSY` cycle, giving a single write pulse; it is 0 at all other times.
  - `cnt` increments each cycle.
  - When `cnt == MEM_LATENCY`, `mem_rdata` is registered into the owner's `rdata` and the state moves to `RESP`.
- **RESP**
  - The owner's `rvalid` is 1.
  - A new grant may occur in the same cycle (back-to-back). If there is no grant, the next state is `IDLE`.
- **Starvation counter** `starve` (4 bits)
  - Increments on each `d_gnt` while `if_req` = 1.
  - Clears on `if_gnt`.
  - Saturates at `STARVE_LIMIT`.
- **Request inputs**
  - Requests and their inputs are ignored outside grant cycles; changes during `BUSY` have no effect.
  - A requester may drop `req` before it is granted; no transaction results.
- **Outputs when no transaction is in flight**
  - `mem_addr`, `mem_wdata`, `mem_size` and `mem_ext` hold their last values.
  - `rdata` holds its last value.
- **Reset** (asynchronous, at any time, including mid-transaction)
  - State goes to `IDLE`; `cnt` and `starve` clear to 0.
  - All outputs go to 0.
  - Any in-flight transaction is abandoned: no `rvalid` is produced for it.

## Timing
- A grant in cycle t drives `mem_*` during cycles t+1 .. t+`MEM_LATENCY`.
- `rvalid` is high in cycle t+`MEM_LATENCY`+1.
- Request-to-response latency is `MEM_LATENCY`+1 cycles.
- Sustained throughput is one access per `MEM_LATENCY`+1 cycles: a grant can occur in the `RESP` cycle itself.
- `gnt` is combinational from `req` and state. `rvalid`, `rdata` and `mem_*` are registered.
- Reset values: `if_gnt`, `d_gnt`, `if_rvalid`, `d_rvalid`, `mem_we`, `mem_ext` = 0; `if_rdata`, `d_rdata`, `mem_addr`, `mem_wdata` = 0; `mem_size` = 0.

## Test plan
- **Single fetch** (`MEM_LATENCY`=2, memory word @0x2000 = 0xDEADBEEF).
  - Stimulus: `if_req`, `if_addr`=0x2000 at cycle 0.
  - Required: `if_gnt`=1 in cycle 0; `mem_addr`=0x2000 in cycles 1–2; `if_rvalid`=1 with `if_rdata`=0xDEADBEEF in cycle 3 only.
- **Store then load**
  - Stimulus: `d_we`=1, `d_addr`=0x2004, `d_wdata`=0x12345678, `d_size`=3 (word); then a load from 0x2004.
  - Required: `mem_we`=1 for exactly one cycle; `d_rvalid` pulses for the store; the load returns 0x12345678.
- **Contention**
  - Stimulus: `if_req` and `d_req` both high in cycle 0.
  - Required: `d_gnt` in cycle 0; `if_gnt` in cycle 3 (`RESP` cycle, back-to-back); `if_rvalid` in cycle 6.
- **Starvation** (`STARVE_LIMIT`=2)
  - Stimulus: `if_req` and `d_req` held high continuously.
  - Required grant order: d, d, if, d, d, if; `starve` returns to 0 after each `if_gnt`.
- **Reset mid-transaction**
  - Stimulus: assert `reset` in cycle 1 of a `d` load.
  - Required: all outputs 0 immediately; no `d_rvalid` ever appears; a new request after reset completes normally.
- **`MEM_LATENCY`=1 boundary**
  - Stimulus: continuous fetch requests.
  - Required: `if_gnt` every 2nd cycle; each `if_rvalid` arrives 2 cycles after its grant.
